// File: rtl/rf_arbiter_pkg.sv
// Shared constants for the register-file arbiter: default sizing and index-width helper.
package rf_arbiter_pkg;

   localparam int DEF_NUM_REQ    = 4;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_IDX_WIDTH  = $clog2(DEF_NUM_REQ);

   // A single requester still needs a 1-bit pointer.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rf_arbiter_rr.sv
// Round-robin arbiter: one-hot grant from a request vector.
// The pointer names the highest-priority requester and moves past the winner on each grant.
module rr_arbiter
   import rf_arbiter_pkg::*;
#(
   parameter int N = DEF_NUM_REQ
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   output logic [N-1:0] grant
);

   localparam int            IW   = idx_width(N);
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   logic [IW-1:0] ptr;
   logic [IW-1:0] ptr_nxt;
   logic [IW-1:0] idx;
   logic          found;

   // Walk the requesters cyclically starting at ptr; the first one asking wins.
   always_comb begin
      grant   = '0;
      ptr_nxt = ptr;
      found   = 1'b0;
      idx     = ptr;
      for (int k = 0; k < N; k++) begin
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            ptr_nxt    = (idx == LAST) ? '0 : idx + 1'b1;
         end
         idx = (idx == LAST) ? '0 : idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (found) begin
         ptr <= ptr_nxt;
      end
   end

endmodule

// File: rtl/rf_arbiter.sv
// Register-file port arbiter: independent round-robin write and read arbitration,
// zero-latency write issue, one-cycle read response with write-to-read bypass.
module rf_arbiter
   import rf_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_REQ-1:0]               wr_valid,
   output logic [NUM_REQ-1:0]               wr_ready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    wr_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    wr_data,
   input  logic [NUM_REQ-1:0]               rd_valid,
   output logic [NUM_REQ-1:0]               rd_ready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    rd_addr,
   output logic [NUM_REQ-1:0]               rd_resp_valid,
   output logic [DATA_WIDTH-1:0]            rd_resp_data,
   output logic                             rf_we,
   output logic [ADDR_WIDTH-1:0]            rf_waddr,
   output logic [DATA_WIDTH-1:0]            rf_din,
   output logic [ADDR_WIDTH-1:0]            rf_raddr,
   input  logic [DATA_WIDTH-1:0]            rf_dout
);

   logic [NUM_REQ-1:0]    wr_req;
   logic [NUM_REQ-1:0]    rd_req;
   logic [NUM_REQ-1:0]    wr_gnt;
   logic [NUM_REQ-1:0]    rd_gnt;
   logic [DATA_WIDTH-1:0] rd_fetch;
   logic                  bypass;
   logic [NUM_REQ-1:0]    resp_valid_q;
   logic [DATA_WIDTH-1:0] resp_data_q;

   // Masking requests during reset keeps every grant-derived output at zero.
   assign wr_req = wr_valid & {NUM_REQ{~rst}};
   assign rd_req = rd_valid & {NUM_REQ{~rst}};

   rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
      .clk   (clk),
      .rst   (rst),
      .req   (wr_req),
      .grant (wr_gnt)
   );

   rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
      .clk   (clk),
      .rst   (rst),
      .req   (rd_req),
      .grant (rd_gnt)
   );

   assign wr_ready = wr_gnt;
   assign rd_ready = rd_gnt;
   assign rf_we    = |wr_gnt;

   always_comb begin
      rf_waddr = '0;
      rf_din   = '0;
      rf_raddr = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rf_waddr = rf_waddr | (wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{wr_gnt[i]}});
         rf_din   = rf_din   | (wr_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{wr_gnt[i]}});
         rf_raddr = rf_raddr | (rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{rd_gnt[i]}});
      end
   end

   // The RF is written at the same edge the read is captured, so forward the write data.
   assign bypass   = rf_we && (rf_waddr == rf_raddr);
   assign rd_fetch = bypass ? rf_din : rf_dout;

   always_ff @(posedge clk) begin
      if (rst) begin
         resp_valid_q <= '0;
         resp_data_q  <= '0;
      end else begin
         resp_valid_q <= rd_gnt;
         if (|rd_gnt) begin
            resp_data_q <= rd_fetch;
         end
      end
   end

   // Reset kills a response already in flight in the same cycle.
   assign rd_resp_valid = resp_valid_q & {NUM_REQ{~rst}};
   assign rd_resp_data  = rst ? '0 : resp_data_q;

endmodule
